// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// arb_pkg : shared source IDs and arbiter state encoding for sram_req_arbiter
// Revision: 1.0
// ============================================================================
package arb_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_INST = 2'd1,
    HOLD_DATA = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// sram_req_arbiter_if : inst/data request channels plus the shared memory port
// Revision: 1.0
// ============================================================================
interface sram_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_W-1:0]     inst_rdata;

  logic                  data_req;
  logic                  data_wr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  logic                  mem_req;
  logic                  mem_wr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter view: answers the two requesters, drives the memory port.
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  // Environment view: pipeline stages and memory bridge.
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/arb_order_fifo.sv
`default_nettype none
// ============================================================================
// arb_order_fifo : 1-bit source-ID FIFO recording address-phase order
// Revision: 1.0
// ============================================================================
module arb_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic empty,
  output logic full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign head_id = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// sram_req_arbiter : shares one SRAM-like port between inst and data channels
// Revision: 1.0
// ============================================================================
module sram_req_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,
  sram_req_arbiter_if.slave   bus
);

  arb_state_e          state_q, state_d;
  logic                sel_src;
  logic                req_act;
  logic                addr_fire;
  logic                fifo_head, fifo_empty, fifo_full;
  logic                resp_valid;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;
  logic                sel_wr;

  // Data has priority in IDLE; a HOLD state locks its source until accepted.
  always_comb begin
    state_d = state_q;
    sel_src = SRC_DATA;
    req_act = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_full && (bus.data_req || bus.inst_req)) begin
          req_act = 1'b1;
          sel_src = bus.data_req ? SRC_DATA : SRC_INST;
          if (!bus.mem_addr_ok) begin
            state_d = bus.data_req ? HOLD_DATA : HOLD_INST;
          end
        end
      end
      HOLD_INST: begin
        req_act = 1'b1;
        sel_src = SRC_INST;
        if (bus.mem_addr_ok) state_d = IDLE;
      end
      HOLD_DATA: begin
        req_act = 1'b1;
        sel_src = SRC_DATA;
        if (bus.mem_addr_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    sel_addr  = bus.data_addr;
    sel_wdata = bus.data_wdata;
    sel_wstrb = bus.data_wstrb;
    sel_wr    = bus.data_wr;
    if (sel_src == SRC_INST) begin
      sel_addr  = bus.inst_addr;
      sel_wdata = '0;
      sel_wstrb = '0;
      sel_wr    = 1'b0;
    end
  end

  // Handshake outputs are held low while reset is asserted.
  assign bus.mem_req   = req_act & ~reset;
  assign bus.mem_wr    = sel_wr;
  assign bus.mem_wstrb = sel_wstrb;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  assign addr_fire        = bus.mem_req & bus.mem_addr_ok;
  assign bus.inst_addr_ok = addr_fire & (sel_src == SRC_INST);
  assign bus.data_addr_ok = addr_fire & (sel_src == SRC_DATA);

  assign resp_valid       = bus.mem_data_ok & ~fifo_empty & ~reset;
  assign bus.inst_data_ok = resp_valid & (fifo_head == SRC_INST);
  assign bus.data_data_ok = resp_valid & (fifo_head == SRC_DATA);
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  arb_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (addr_fire),
    .push_id (sel_src),
    .pop     (resp_valid),
    .head_id (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_req_arbiter : directed checks of arbitration, ordering and reset
// Revision: 1.0
// ============================================================================
module tb_sram_req_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_req_arbiter #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = '0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_wstrb  = '0;
    bus.data_addr   = '0;
    bus.data_wdata  = '0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  // Inputs change at the falling edge; checks follow 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    next_cycle();
    bus.inst_req    = 1'b1;
    bus.mem_data_ok = 1'b1;
    #1;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_inst_addr_ok", bus.inst_addr_ok, 0);
    check("rst_inst_data_ok", bus.inst_data_ok, 0);
    check("rst_data_data_ok", bus.data_data_ok, 0);
    clear_inputs();
    next_cycle();
    reset = 1'b0;
    #1;
    check("idle_mem_req", bus.mem_req, 0);

    // 1: both request, immediate accept -> data first, inst next
    next_cycle();
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h0000_1000;
    bus.data_req    = 1'b1;
    bus.data_addr   = 32'h0000_2000;
    bus.data_wr     = 1'b1;
    bus.data_wstrb  = 4'hF;
    bus.data_wdata  = 32'hDEAD_BEEF;
    bus.mem_addr_ok = 1'b1;
    #1;
    check("t1_mem_req", bus.mem_req, 1);
    check("t1_mem_addr_data", bus.mem_addr, 32'h2000);
    check("t1_mem_wr", bus.mem_wr, 1);
    check("t1_mem_wstrb", bus.mem_wstrb, 4'hF);
    check("t1_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("t1_data_addr_ok", bus.data_addr_ok, 1);
    check("t1_inst_addr_ok_lo", bus.inst_addr_ok, 0);
    next_cycle();
    bus.data_req = 1'b0;
    #1;
    check("t1_mem_addr_inst", bus.mem_addr, 32'h1000);
    check("t1_inst_wr", bus.mem_wr, 0);
    check("t1_inst_wstrb", bus.mem_wstrb, 0);
    check("t1_inst_addr_ok", bus.inst_addr_ok, 1);
    check("t1_data_addr_ok_lo", bus.data_addr_ok, 0);
    next_cycle();
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'hAA;
    #1;
    check("t1_resp0_data_ok", bus.data_data_ok, 1);
    check("t1_resp0_inst_ok", bus.inst_data_ok, 0);
    check("t1_resp0_rdata", bus.data_rdata, 32'hAA);
    next_cycle();
    bus.mem_rdata = 32'hBB;
    #1;
    check("t1_resp1_inst_ok", bus.inst_data_ok, 1);
    check("t1_resp1_data_ok", bus.data_data_ok, 0);
    check("t1_resp1_rdata", bus.inst_rdata, 32'hBB);

    // 2: inst held in HOLD_INST, data arrives meanwhile, no preemption
    next_cycle();
    clear_inputs();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h3000;
    #1;
    check("t2_c0_mem_req", bus.mem_req, 1);
    check("t2_c0_addr", bus.mem_addr, 32'h3000);
    check("t2_c0_inst_addr_ok", bus.inst_addr_ok, 0);
    next_cycle();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h4000;
    #1;
    check("t2_c1_addr", bus.mem_addr, 32'h3000);
    check("t2_c1_wr", bus.mem_wr, 0);
    check("t2_c1_data_addr_ok", bus.data_addr_ok, 0);
    next_cycle();
    #1;
    check("t2_c2_addr", bus.mem_addr, 32'h3000);
    next_cycle();
    bus.mem_addr_ok = 1'b1;
    #1;
    check("t2_c3_inst_addr_ok", bus.inst_addr_ok, 1);
    check("t2_c3_data_addr_ok", bus.data_addr_ok, 0);
    next_cycle();
    bus.inst_req = 1'b0;
    #1;
    check("t2_c4_addr", bus.mem_addr, 32'h4000);
    check("t2_c4_data_addr_ok", bus.data_addr_ok, 1);
    next_cycle();
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h55;
    #1;
    check("t2_resp0_inst_ok", bus.inst_data_ok, 1);
    next_cycle();
    bus.mem_rdata = 32'h66;
    #1;
    check("t2_resp1_data_ok", bus.data_data_ok, 1);
    check("t2_resp1_inst_ok", bus.inst_data_ok, 0);

    // 3: inst A, data B, inst C; responses routed in order
    next_cycle();
    clear_inputs();
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h100;
    bus.mem_addr_ok = 1'b1;
    #1;
    check("t3_a_addr_ok", bus.inst_addr_ok, 1);
    next_cycle();
    bus.inst_req  = 1'b0;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h200;
    #1;
    check("t3_b_addr_ok", bus.data_addr_ok, 1);
    next_cycle();
    bus.data_req  = 1'b0;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h300;
    #1;
    check("t3_c_addr_ok", bus.inst_addr_ok, 1);
    next_cycle();
    clear_inputs();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h11;
    #1;
    check("t3_r11_inst_ok", bus.inst_data_ok, 1);
    check("t3_r11_data_ok", bus.data_data_ok, 0);
    check("t3_r11_rdata", bus.inst_rdata, 32'h11);
    next_cycle();
    bus.mem_rdata = 32'h22;
    #1;
    check("t3_r22_data_ok", bus.data_data_ok, 1);
    check("t3_r22_inst_ok", bus.inst_data_ok, 0);
    check("t3_r22_rdata", bus.data_rdata, 32'h22);
    next_cycle();
    bus.mem_rdata = 32'h33;
    #1;
    check("t3_r33_inst_ok", bus.inst_data_ok, 1);
    check("t3_r33_rdata", bus.inst_rdata, 32'h33);

    // 4: four outstanding -> fifth request blocked even with a pop that cycle
    next_cycle();
    clear_inputs();
    bus.inst_req    = 1'b1;
    bus.mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.inst_addr = 32'h1000 + 32'(i * 4);
      #1;
      check("t4_fill_addr_ok", bus.inst_addr_ok, 1);
      next_cycle();
    end
    bus.inst_addr   = 32'h1010;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h77;
    #1;
    check("t4_full_mem_req", bus.mem_req, 0);
    check("t4_full_addr_ok", bus.inst_addr_ok, 0);
    check("t4_full_pop_ok", bus.inst_data_ok, 1);
    next_cycle();
    bus.mem_data_ok = 1'b0;
    #1;
    check("t4_after_mem_req", bus.mem_req, 1);
    check("t4_after_addr_ok", bus.inst_addr_ok, 1);
    check("t4_after_addr", bus.mem_addr, 32'h1010);
    next_cycle();
    clear_inputs();
    bus.mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_drain_inst_ok", bus.inst_data_ok, 1);
      next_cycle();
    end

    // 5: spurious response on empty FIFO, then a normal data write
    #1;
    check("t5_spur_inst_ok", bus.inst_data_ok, 0);
    check("t5_spur_data_ok", bus.data_data_ok, 0);
    next_cycle();
    clear_inputs();
    bus.data_req    = 1'b1;
    bus.data_wr     = 1'b1;
    bus.data_wstrb  = 4'h3;
    bus.data_addr   = 32'h500;
    bus.data_wdata  = 32'h1234_5678;
    bus.mem_addr_ok = 1'b1;
    #1;
    check("t5_data_addr_ok", bus.data_addr_ok, 1);
    check("t5_wstrb", bus.mem_wstrb, 4'h3);
    next_cycle();
    clear_inputs();
    bus.mem_data_ok = 1'b1;
    #1;
    check("t5_data_ok", bus.data_data_ok, 1);
    check("t5_inst_ok_lo", bus.inst_data_ok, 0);

    // 6: reset with two outstanding discards them
    next_cycle();
    clear_inputs();
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h600;
    bus.mem_addr_ok = 1'b1;
    #1;
    check("t6_pre0_addr_ok", bus.inst_addr_ok, 1);
    next_cycle();
    bus.inst_req  = 1'b0;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h700;
    #1;
    check("t6_pre1_addr_ok", bus.data_addr_ok, 1);
    next_cycle();
    clear_inputs();
    bus.inst_req = 1'b1;
    reset        = 1'b1;
    #1;
    check("t6_rst_mem_req", bus.mem_req, 0);
    next_cycle();
    bus.mem_data_ok = 1'b1;
    #1;
    check("t6_rst2_mem_req", bus.mem_req, 0);
    check("t6_rst2_inst_ok", bus.inst_data_ok, 0);
    next_cycle();
    reset        = 1'b0;
    bus.inst_req = 1'b0;
    #1;
    check("t6_post_inst_ok", bus.inst_data_ok, 0);
    check("t6_post_data_ok", bus.data_data_ok, 0);
    next_cycle();
    clear_inputs();
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h800;
    bus.mem_addr_ok = 1'b1;
    #1;
    check("t6_norm_addr_ok", bus.inst_addr_ok, 1);
    next_cycle();
    clear_inputs();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h99;
    #1;
    check("t6_norm_inst_ok", bus.inst_data_ok, 1);
    check("t6_norm_rdata", bus.inst_rdata, 32'h99);
    next_cycle();
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch request channel and the data (load/store) request channel.
- Each channel uses the req / addr_ok / data_ok handshake.
- The block arbitrates address phases, holds a granted request until it is accepted, and records request order so each data_ok/rdata is routed to the requester that issued it.
- It sits between the IF/MEM pipeline stages and the memory bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions. Power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  instruction read request.
- inst_addr  in  ADDR_W  instruction address.
- inst_addr_ok  out  1  address phase of inst request accepted.
- inst_data_ok  out  1  inst read data valid.
- inst_rdata  out  DATA_W  inst read data.
- data_req  in  1  data request.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  DATA_W/8  byte strobes.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_addr_ok  out  1  address phase of data request accepted.
- data_data_ok  out  1  data read returned or write completed.
- data_rdata  out  DATA_W  data read data.
- mem_req  out  1  request to memory.
- mem_wr  out  1  write flag to memory.
- mem_wstrb  out  DATA_W/8  strobes to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_addr_ok  in  1  memory accepted the address phase.
- mem_data_ok  in  1  memory response valid.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Handshake rule: a requester holds req and its payload stable from assertion until it sees addr_ok. The address phase completes in a cycle where mem_req and mem_addr_ok are both 1.
- Inst-channel mapping: mem_wr = 0 and mem_wstrb = 0 when the inst channel is selected.
- FSM states:
  - IDLE:
    - If not full and (data_req or inst_req), select a source combinationally (data_req has priority over inst_req), assert mem_req and drive that source's payload in the same cycle.
    - If mem_addr_ok arrives that cycle, stay in IDLE.
    - Otherwise, move to HOLD_DATA or HOLD_INST to match the selection.
  - HOLD_DATA / HOLD_INST:
    - mem_req = 1 and the payload is muxed from the locked source, regardless of the other request (no preemption).
    - On mem_addr_ok, return to IDLE.
- addr_ok routing:
  - inst_addr_ok = mem_addr_ok & mem_req & (selected source is inst).
  - data_addr_ok is the same with source = data.
  - The non-selected channel's addr_ok is 0.
- Order FIFO (1-bit source ID, depth MAX_OUTSTANDING):
  - Push the selected source ID on each completed address phase.
  - Pop on mem_data_ok.
- Response routing:
  - inst_data_ok = mem_data_ok & ~empty & (head == inst).
  - data_data_ok is the same with head == data.
  - inst_rdata and data_rdata are both driven with mem_rdata; consumers qualify it with their data_ok.
- Full FIFO:
  - In IDLE with the FIFO full, mem_req = 0 and no grant is made, even if a pop occurs in the same cycle.
  - A HOLD state can only be entered when the FIFO is not full, so HOLD never sees a full FIFO.
- Simultaneous push and pop: the count is unchanged and pointers advance correctly, including wrap-around at MAX_OUTSTANDING.
- Spurious mem_data_ok with the FIFO empty: ignored; both data_ok outputs stay 0 and the count is not decremented.
- Reset values, applied when reset = 1 at the clock edge:
  - state = IDLE, FIFO empty, pointers and count = 0.
  - All data_ok and addr_ok outputs are 0 and mem_req is 0.
- Reset mid-transaction: outstanding entries are discarded. Later mem_data_ok pulses fall under the empty-FIFO rule.
- Latency: the arbiter adds zero cycles to both address and response paths. Paths from mem_addr_ok to the addr_ok outputs and from mem_data_ok to the data_ok outputs are combinational.

Decomposition:
- Shared package (arb_pkg):
  - constants SRC_INST = 1'b0 and SRC_DATA = 1'b1;
  - enum for the arbiter states (IDLE, HOLD_INST, HOLD_DATA).
- Sub-module arb_order_fifo:
  - synchronous 1-bit FIFO, parameter DEPTH;
  - ports push, push_id, pop, head_id, empty, full.

Test Plan:
1. Both inst_req and data_req asserted in IDLE, mem_addr_ok = 1 the same cycle → mem_req = 1, mem_addr = data_addr, data_addr_ok = 1, inst_addr_ok = 0; next cycle inst is granted.
2. inst_req asserted, mem_addr_ok held 0 for 3 cycles, data_req rises in cycle 2 → mem_addr stays inst_addr (HOLD_INST); on addr_ok, inst_addr_ok = 1 and data is granted the next cycle.
3. Issue inst A, data B (read), inst C; return three mem_data_ok pulses with rdata 0x11, 0x22, 0x33 → inst_data_ok with 0x11, then data_data_ok with 0x22, then inst_data_ok with 0x33.
4. Fill 4 outstanding with no responses → mem_req = 0 in the 5th request cycle even when mem_data_ok pops that cycle; the grant occurs the following cycle.
5. Spurious mem_data_ok with the FIFO empty → no data_ok asserted; a subsequent normal transaction is routed correctly.
6. Assert reset with 2 outstanding entries, then pulse mem_data_ok → no data_ok asserted, mem_req = 0 during reset, normal operation afterwards.
